// File: rtl/id_stage.sv
// Instruction-decode stage of a 16-bit in-order pipeline.
// It holds the IF/ID register and an 8x16 register file with R0 tied to zero.
// It resolves operands with MEM forwarding and WB bypass, detects load-use and
// branch-operand hazards, and resolves branches, jumps, calls and returns
// inside ID. It also fills the ID/EX register and counts taken redirects.
//
// Fetch control: stall=1 means fetch must hold its PC/instruction because the
// IF/ID register will not load this edge. kill=1 means the instruction fetch
// presents this cycle is squashed and fetch redirects according to PCSrc.
// The two are never asserted together, because a stalled ID never redirects.
module id_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] if_instruction,
    input  logic [15:0] if_new_pc,
    input  logic        ex_mem_read,
    input  logic        ex_reg_write,
    input  logic [2:0]  ex_rd,
    input  logic        mem_reg_write,
    input  logic [2:0]  mem_rd,
    input  logic [15:0] mem_value,
    input  logic        wb_we,
    input  logic [2:0]  wb_rd,
    input  logic [15:0] wb_data,
    output logic        stall,
    output logic        kill,
    output logic [1:0]  PCSrc,
    output logic [15:0] Branch_TA,
    output logic [15:0] Jump_TA,
    output logic [15:0] For_TA,
    output logic [3:0]  idex_opcode,
    output logic [2:0]  idex_func,
    output logic [2:0]  idex_rd,
    output logic [15:0] idex_a,
    output logic [15:0] idex_b,
    output logic [15:0] idex_imm,
    output logic [15:0] idex_pc1,
    output logic        idex_reg_write,
    output logic        idex_mem_read,
    output logic        idex_mem_write,
    output logic [15:0] num_branches_taken
);

    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_ADDI  = 4'd1;
    localparam logic [3:0] OP_LW    = 4'd2;
    localparam logic [3:0] OP_SW    = 4'd3;
    localparam logic [3:0] OP_BEQ   = 4'd4;
    localparam logic [3:0] OP_BNE   = 4'd5;
    localparam logic [3:0] OP_JMP   = 4'd6;
    localparam logic [3:0] OP_CALL  = 4'd7;
    localparam logic [3:0] OP_RET   = 4'd8;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [2:0]  func;
        logic [2:0]  rd;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] imm;
        logic [15:0] pc1;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } idex_t;

    logic [15:0] r_ifid_instr;
    logic [15:0] r_ifid_pc1;
    logic [15:0] r_rf [0:7];
    idex_t       r_idex;
    logic [15:0] r_nbt;

    logic [3:0]  w_op;
    logic [2:0]  w_rd;
    logic [2:0]  w_rs;
    logic [2:0]  w_rt;
    logic [2:0]  w_func;
    logic [15:0] w_simm;
    logic [15:0] w_soff;
    logic [15:0] w_opnd_rs;
    logic [15:0] w_opnd_rt;
    logic [15:0] w_opnd_rd;
    logic [15:0] w_opnd_r7;
    logic        w_use_rs;
    logic        w_use_rt;
    logic        w_use_rd;
    logic        w_use_r7;
    logic        w_is_br;
    logic        w_is_ret;
    logic [1:0]  w_pcsrc_raw;
    idex_t       w_dec;
    idex_t       w_idex_nx;
    logic        w_load_use;
    logic        w_ctrl_hazard;

    // Operand resolution: R0 is zero, the MEM result beats the WB write, and
    // the register file is the fallback.
    function automatic logic [15:0] f_operand(
        input logic [2:0]  i_sel,
        input logic [15:0] i_rf_val,
        input logic        i_mem_we,
        input logic [2:0]  i_mem_rd,
        input logic [15:0] i_mem_val,
        input logic        i_wb_we,
        input logic [2:0]  i_wb_rd,
        input logic [15:0] i_wb_val
    );
        if (i_sel == 3'd0)
            return 16'h0000;
        else if (i_mem_we && (i_mem_rd == i_sel))
            return i_mem_val;
        else if (i_wb_we && (i_wb_rd == i_sel))
            return i_wb_val;
        else
            return i_rf_val;
    endfunction

    assign w_op   = r_ifid_instr[15:12];
    assign w_rd   = r_ifid_instr[11:9];
    assign w_rs   = r_ifid_instr[8:6];
    assign w_rt   = r_ifid_instr[5:3];
    assign w_func = r_ifid_instr[2:0];
    assign w_simm = {{10{r_ifid_instr[5]}}, r_ifid_instr[5:0]};
    assign w_soff = {{4{r_ifid_instr[11]}}, r_ifid_instr[11:0]};

    assign w_opnd_rs = f_operand(w_rs, r_rf[w_rs], mem_reg_write, mem_rd, mem_value, wb_we, wb_rd, wb_data);
    assign w_opnd_rt = f_operand(w_rt, r_rf[w_rt], mem_reg_write, mem_rd, mem_value, wb_we, wb_rd, wb_data);
    assign w_opnd_rd = f_operand(w_rd, r_rf[w_rd], mem_reg_write, mem_rd, mem_value, wb_we, wb_rd, wb_data);
    assign w_opnd_r7 = f_operand(3'd7, r_rf[7], mem_reg_write, mem_rd, mem_value, wb_we, wb_rd, wb_data);

    // Decode the IF/ID instruction into source usage, redirect intent and the unstalled ID/EX payload.
    always_comb begin
        w_use_rs      = 1'b0;
        w_use_rt      = 1'b0;
        w_use_rd      = 1'b0;
        w_use_r7      = 1'b0;
        w_is_br       = 1'b0;
        w_is_ret      = 1'b0;
        w_pcsrc_raw   = 2'b00;
        w_dec         = '0;
        w_dec.opcode  = w_op;
        w_dec.func    = w_func;
        w_dec.rd      = w_rd;
        w_dec.pc1     = r_ifid_pc1;
        case (w_op)
            OP_RTYPE: begin
                w_use_rs        = 1'b1;
                w_use_rt        = 1'b1;
                w_dec.a         = w_opnd_rs;
                w_dec.b         = w_opnd_rt;
                w_dec.reg_write = (w_rd != 3'd0);
            end
            OP_ADDI, OP_LW: begin
                w_use_rs        = 1'b1;
                w_dec.a         = w_opnd_rs;
                w_dec.imm       = w_simm;
                w_dec.reg_write = (w_rd != 3'd0);
                w_dec.mem_read  = (w_op == OP_LW);
            end
            OP_SW: begin
                w_use_rs        = 1'b1;
                w_use_rd        = 1'b1;
                w_dec.a         = w_opnd_rs;
                w_dec.b         = w_opnd_rd;
                w_dec.imm       = w_simm;
                w_dec.mem_write = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                w_use_rs = 1'b1;
                w_use_rd = 1'b1;
                w_is_br  = 1'b1;
                w_dec.a  = w_opnd_rs;
                w_dec.b  = w_opnd_rd;
                if ((w_opnd_rd == w_opnd_rs) == (w_op == OP_BEQ))
                    w_pcsrc_raw = 2'b01;
            end
            OP_JMP: begin
                w_pcsrc_raw = 2'b10;
            end
            OP_CALL: begin
                w_dec.rd        = 3'd7;
                w_dec.a         = r_ifid_pc1;
                w_dec.reg_write = 1'b1;
                w_pcsrc_raw     = 2'b10;
            end
            OP_RET: begin
                w_use_r7    = 1'b1;
                w_is_ret    = 1'b1;
                w_pcsrc_raw = 2'b11;
            end
            default: begin
                w_dec = '0;
            end
        endcase
    end

    assign w_load_use = ex_mem_read && (ex_rd != 3'd0) &&
                        ((w_use_rs && (ex_rd == w_rs)) ||
                         (w_use_rt && (ex_rd == w_rt)) ||
                         (w_use_rd && (ex_rd == w_rd)) ||
                         (w_use_r7 && (ex_rd == 3'd7)));

    // Branch compares and RET targets are resolved in ID, so any ALU result still in EX is too late.
    assign w_ctrl_hazard = ex_reg_write && (ex_rd != 3'd0) &&
                           ((w_is_br && ((ex_rd == w_rs) || (ex_rd == w_rd))) ||
                            (w_is_ret && (ex_rd == 3'd7)));

    assign stall     = w_load_use | w_ctrl_hazard;
    assign PCSrc     = stall ? 2'b00 : w_pcsrc_raw;
    assign kill      = (PCSrc != 2'b00);
    assign w_idex_nx = stall ? '0 : w_dec;

    assign Branch_TA = r_ifid_pc1 + w_simm;
    assign Jump_TA   = r_ifid_pc1 + w_soff;
    assign For_TA    = rst_n ? w_opnd_r7 : 16'h0000;

    // IF/ID register: follows fetch unless ID is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ifid_instr <= '0;
            r_ifid_pc1   <= '0;
        end else if (!stall) begin
            r_ifid_instr <= if_instruction;
            r_ifid_pc1   <= if_new_pc;
        end
    end

    // Register file write port; R0 is never written so it stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++)
                r_rf[i] <= '0;
        end else if (wb_we && (wb_rd != 3'd0)) begin
            r_rf[wb_rd] <= wb_data;
        end
    end

    // ID/EX register: takes the decoded instruction, or a bubble while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_idex <= '0;
        else
            r_idex <= w_idex_nx;
    end

    // Taken-redirect counter, saturating at all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_nbt <= '0;
        else if (kill && (r_nbt != 16'hFFFF))
            r_nbt <= r_nbt + 16'd1;
    end

    assign idex_opcode        = r_idex.opcode;
    assign idex_func          = r_idex.func;
    assign idex_rd            = r_idex.rd;
    assign idex_a             = r_idex.a;
    assign idex_b             = r_idex.b;
    assign idex_imm           = r_idex.imm;
    assign idex_pc1           = r_idex.pc1;
    assign idex_reg_write     = r_idex.reg_write;
    assign idex_mem_read      = r_idex.mem_read;
    assign idex_mem_write     = r_idex.mem_write;
    assign num_branches_taken = r_nbt;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: a behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] if_instruction, if_new_pc;
    logic        ex_mem_read, ex_reg_write;
    logic [2:0]  ex_rd;
    logic        mem_reg_write;
    logic [2:0]  mem_rd;
    logic [15:0] mem_value;
    logic        wb_we;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic        stall, kill;
    logic [1:0]  PCSrc;
    logic [15:0] Branch_TA, Jump_TA, For_TA;
    logic [3:0]  idex_opcode;
    logic [2:0]  idex_func, idex_rd;
    logic [15:0] idex_a, idex_b, idex_imm, idex_pc1;
    logic        idex_reg_write, idex_mem_read, idex_mem_write;
    logic [15:0] num_branches_taken;

    int total = 0;
    int bad = 0;
    logic check_en = 1'b0;

    id_stage dut (
        .clk(clk), .rst_n(rst_n),
        .if_instruction(if_instruction), .if_new_pc(if_new_pc),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_value(mem_value),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall(stall), .kill(kill), .PCSrc(PCSrc),
        .Branch_TA(Branch_TA), .Jump_TA(Jump_TA), .For_TA(For_TA),
        .idex_opcode(idex_opcode), .idex_func(idex_func), .idex_rd(idex_rd),
        .idex_a(idex_a), .idex_b(idex_b), .idex_imm(idex_imm), .idex_pc1(idex_pc1),
        .idex_reg_write(idex_reg_write), .idex_mem_read(idex_mem_read),
        .idex_mem_write(idex_mem_write), .num_branches_taken(num_branches_taken)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [3:0]  op;
        logic [2:0]  func;
        logic [2:0]  rd;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] imm;
        logic [15:0] pc1;
        logic        rw;
        logic        mr;
        logic        mw;
    } idex_m_t;

    typedef struct packed {
        logic        stall;
        logic [1:0]  pcsrc;
        logic [15:0] bta;
        logic [15:0] jta;
        logic [15:0] fta;
        idex_m_t     nx;
    } exp_t;

    logic [15:0] m_rf [0:7];
    logic [15:0] m_ifid_instr, m_ifid_pc1, m_cnt;
    idex_m_t     m_idex;

    function automatic logic [15:0] opnd(input logic [2:0] r);
        if (r == 3'd0) return 16'h0000;
        if (mem_reg_write && mem_rd == r) return mem_value;
        if (wb_we && wb_rd == r) return wb_data;
        return m_rf[r];
    endfunction

    function automatic exp_t model_eval();
        exp_t e;
        logic [15:0] ins, simm, soff;
        logic [3:0] op;
        logic [2:0] rd, rs, rt;
        logic [7:0] reads, ctrl_reads;
        ins = m_ifid_instr;
        op = ins[15:12]; rd = ins[11:9]; rs = ins[8:6]; rt = ins[5:3];
        simm = {{10{ins[5]}}, ins[5:0]};
        soff = {{4{ins[11]}}, ins[11:0]};
        e = '0; reads = '0; ctrl_reads = '0;
        case (op)
            4'd0: begin reads[rs] = 1'b1; reads[rt] = 1'b1; end
            4'd1, 4'd2: reads[rs] = 1'b1;
            4'd3: begin reads[rs] = 1'b1; reads[rd] = 1'b1; end
            4'd4, 4'd5: begin reads[rs] = 1'b1; reads[rd] = 1'b1; ctrl_reads = reads; end
            4'd8: begin reads[7] = 1'b1; ctrl_reads[7] = 1'b1; end
            default: ;
        endcase
        e.stall = (ex_mem_read && ex_rd != 3'd0 && reads[ex_rd]) ||
                  (ex_reg_write && ex_rd != 3'd0 && ctrl_reads[ex_rd]);
        e.bta = m_ifid_pc1 + simm;
        e.jta = m_ifid_pc1 + soff;
        e.fta = rst_n ? opnd(3'd7) : 16'h0000;
        if (!e.stall) begin
            if (op == 4'd4 && opnd(rd) == opnd(rs)) e.pcsrc = 2'b01;
            if (op == 4'd5 && opnd(rd) != opnd(rs)) e.pcsrc = 2'b01;
            if (op == 4'd6 || op == 4'd7) e.pcsrc = 2'b10;
            if (op == 4'd8) e.pcsrc = 2'b11;
            if (op <= 4'd8) begin
                e.nx.op   = op;
                e.nx.func = ins[2:0];
                e.nx.rd   = (op == 4'd7) ? 3'd7 : rd;
                e.nx.pc1  = m_ifid_pc1;
                if (op <= 4'd5) e.nx.a = opnd(rs);
                if (op == 4'd7) e.nx.a = m_ifid_pc1;
                if (op == 4'd0) e.nx.b = opnd(rt);
                if (op >= 4'd3 && op <= 4'd5) e.nx.b = opnd(rd);
                if (op >= 4'd1 && op <= 4'd3) e.nx.imm = simm;
                e.nx.rw = ((op <= 4'd2) && rd != 3'd0) || op == 4'd7;
                e.nx.mr = (op == 4'd2);
                e.nx.mw = (op == 4'd3);
            end
        end
        return e;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
        m_ifid_instr = 16'h0000;
        m_ifid_pc1 = 16'h0000;
        m_cnt = 16'h0000;
        m_idex = '0;
    endtask

    initial model_clear();

    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        if (!rst_n) begin
            model_clear();
        end else begin
            e = model_eval();
            if (wb_we && wb_rd != 3'd0) m_rf[wb_rd] = wb_data;
            if (!e.stall) begin
                m_ifid_instr = if_instruction;
                m_ifid_pc1 = if_new_pc;
            end
            m_idex = e.nx;
            if (e.pcsrc != 2'b00 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        exp_t e;
        e = model_eval();
        chk("stall", 16'(stall), 16'(e.stall));
        chk("pcsrc", 16'(PCSrc), 16'(e.pcsrc));
        chk("kill", 16'(kill), 16'(e.pcsrc != 2'b00));
        chk("stall_kill_excl", 16'(stall & kill), 16'h0000);
        chk("branch_ta", Branch_TA, e.bta);
        chk("jump_ta", Jump_TA, e.jta);
        chk("for_ta", For_TA, e.fta);
        chk("idex_opcode", 16'(idex_opcode), 16'(m_idex.op));
        chk("idex_func", 16'(idex_func), 16'(m_idex.func));
        chk("idex_rd", 16'(idex_rd), 16'(m_idex.rd));
        chk("idex_a", idex_a, m_idex.a);
        chk("idex_b", idex_b, m_idex.b);
        chk("idex_imm", idex_imm, m_idex.imm);
        chk("idex_pc1", idex_pc1, m_idex.pc1);
        chk("idex_reg_write", 16'(idex_reg_write), 16'(m_idex.rw));
        chk("idex_mem_read", 16'(idex_mem_read), 16'(m_idex.mr));
        chk("idex_mem_write", 16'(idex_mem_write), 16'(m_idex.mw));
        chk("num_branches", num_branches_taken, m_cnt);
    endtask

    always @(negedge clk) begin
        #2;
        if (check_en) compare_all();
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        if_instruction = 16'h0000; if_new_pc = 16'h0000;
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd = 3'd0;
        mem_reg_write = 1'b0; mem_rd = 3'd0; mem_value = 16'h0000;
        wb_we = 1'b0; wb_rd = 3'd0; wb_data = 16'h0000;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, 16'(stall), 16'h0000);
        chk({tag, "_kill"}, 16'(kill), 16'h0000);
        chk({tag, "_pcsrc"}, 16'(PCSrc), 16'h0000);
        chk({tag, "_branch_ta"}, Branch_TA, 16'h0000);
        chk({tag, "_jump_ta"}, Jump_TA, 16'h0000);
        chk({tag, "_for_ta"}, For_TA, 16'h0000);
        chk({tag, "_idex_rd"}, 16'(idex_rd), 16'h0000);
        chk({tag, "_idex_a"}, idex_a, 16'h0000);
        chk({tag, "_idex_pc1"}, idex_pc1, 16'h0000);
        chk({tag, "_idex_rw"}, 16'(idex_reg_write), 16'h0000);
        chk({tag, "_idex_mr"}, 16'(idex_mem_read), 16'h0000);
        chk({tag, "_count"}, num_branches_taken, 16'h0000);
    endtask

    function automatic logic [15:0] rand_val();
        if ($urandom_range(0, 1) == 0) return 16'($urandom_range(0, 3));
        return 16'($urandom);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        idle();
        @(posedge clk);
        check_en = 1'b1;
        cyc(); #3;
        chk_all_zero("reset");

        cyc(); rst_n = 1'b1;
        wb_we = 1'b1; wb_rd = 3'd1; wb_data = 16'd5;
        cyc(); wb_rd = 3'd2;
        cyc(); wb_we = 1'b0; if_instruction = 16'h4283; if_new_pc = 16'h0010;

        // BEQ R1,R2,+3 with equal operands
        cyc(); idle(); #3;
        chk("beq_pcsrc", 16'(PCSrc), 16'h0001);
        chk("beq_target", Branch_TA, 16'h0013);
        chk("beq_kill", 16'(kill), 16'h0001);
        chk("beq_count_before", num_branches_taken, 16'h0000);
        cyc(); #3;
        chk("beq_count_after", num_branches_taken, 16'h0001);
        if_instruction = 16'h7FFE; if_new_pc = 16'h0001;

        // CALL with off12 = -2
        cyc(); idle(); #3;
        chk("call_target", Jump_TA, 16'hFFFF);
        chk("call_pcsrc", 16'(PCSrc), 16'h0002);
        cyc(); #3;
        chk("call_idex_rd", 16'(idex_rd), 16'h0007);
        chk("call_idex_a", idex_a, 16'h0001);
        chk("call_idex_rw", 16'(idex_reg_write), 16'h0001);
        chk("call_count", num_branches_taken, 16'h0002);
        if_instruction = 16'h18C1; if_new_pc = 16'h0030;

        // ADDI R4,R3,1 with MEM and WB both targeting R3
        cyc(); idle();
        mem_reg_write = 1'b1; mem_rd = 3'd3; mem_value = 16'hABCD;
        wb_we = 1'b1; wb_rd = 3'd3; wb_data = 16'h1111;
        cyc(); idle(); #3;
        chk("fwd_priority_a", idex_a, 16'hABCD);
        chk("fwd_addi_imm", idex_imm, 16'h0001);
        chk("fwd_addi_rd", 16'(idex_rd), 16'h0004);
        wb_we = 1'b1; wb_rd = 3'd0; wb_data = 16'h00FF;
        if_instruction = 16'h0A00; if_new_pc = 16'h0040;

        // ADD R5,R0,R0 after an attempted R0 write, with R0 also on both forward paths
        cyc(); idle();
        wb_we = 1'b1; wb_rd = 3'd0; wb_data = 16'h00FF;
        mem_reg_write = 1'b1; mem_rd = 3'd0; mem_value = 16'hFFFF;
        cyc(); idle(); #3;
        chk("r0_a", idex_a, 16'h0000);
        chk("r0_b", idex_b, 16'h0000);
        chk("r0_rd", 16'(idex_rd), 16'h0005);
        if_instruction = 16'h0660; if_new_pc = 16'h0020;

        // Load-use: LW R1 in EX, ADD R3,R1,R4 in ID
        cyc(); idle();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 3'd1;
        #3;
        chk("lu_stall", 16'(stall), 16'h0001);
        chk("lu_kill", 16'(kill), 16'h0000);
        chk("lu_pcsrc", 16'(PCSrc), 16'h0000);
        cyc(); idle(); #3;
        chk("lu_released", 16'(stall), 16'h0000);
        chk("lu_bubble_rd", 16'(idex_rd), 16'h0000);
        chk("lu_bubble_rw", 16'(idex_reg_write), 16'h0000);
        chk("lu_bubble_op", 16'(idex_opcode), 16'h0000);
        cyc(); #3;
        chk("lu_issue_rd", 16'(idex_rd), 16'h0003);
        chk("lu_issue_rw", 16'(idex_reg_write), 16'h0001);
        chk("lu_issue_a", idex_a, 16'h0005);
        if_instruction = 16'h0660; if_new_pc = 16'h0022;

        // Reset asserted in the middle of a load-use stall
        cyc(); idle();
        ex_mem_read = 1'b1; ex_rd = 3'd1;
        #3;
        chk("rst_stall_pre", 16'(stall), 16'h0001);
        #1 rst_n = 1'b0;
        #2;
        chk_all_zero("midrst");
        cyc(); idle(); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(); #3;
            chk("post_rst_pcsrc", 16'(PCSrc), 16'h0000);
            chk("post_rst_stall", 16'(stall), 16'h0000);
        end

        // JMP stream long enough to saturate the counter
        cyc(); if_instruction = 16'h6000; if_new_pc = 16'h0100;
        repeat (65540) cyc();
        #3;
        chk("sat_count", num_branches_taken, 16'hFFFF);
        chk("sat_pcsrc", 16'(PCSrc), 16'h0002);
        cyc(); #3;
        chk("sat_hold", num_branches_taken, 16'hFFFF);

        // Randomized traffic from a clean state
        cyc(); idle(); rst_n = 1'b0;
        cyc(); rst_n = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] op;
            cyc();
            op = ($urandom_range(0, 9) == 9) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            if_instruction = {op, 12'($urandom)};
            if_new_pc = 16'($urandom);
            ex_mem_read = ($urandom_range(0, 3) == 0);
            ex_reg_write = 1'($urandom_range(0, 1));
            ex_rd = 3'($urandom_range(0, 7));
            mem_reg_write = 1'($urandom_range(0, 1));
            mem_rd = 3'($urandom_range(0, 7));
            mem_value = rand_val();
            wb_we = ($urandom_range(0, 3) != 0);
            wb_rd = 3'($urandom_range(0, 7));
            wb_data = rand_val();
            if ($urandom_range(0, 299) == 0) begin
                #4 rst_n = 1'b0;
                cyc(); rst_n = 1'b1;
            end
        end

        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 if_instruction  input  16  instruction presented by fetch (already zeroed by fetch when kill=1).
REQ-004 if_new_pc  input  16  PC+1 of the presented instruction.
REQ-005 ex_mem_read, ex_reg_write  input  1 each  instruction now in EX is a load / writes a register.
REQ-006 ex_rd  input  3  destination register of the instruction in EX.
REQ-007 mem_reg_write  input  1, mem_rd  input  3, mem_value  input  16  MEM-stage result for forwarding.
REQ-008 wb_we  input  1, wb_rd  input  3, wb_data  input  16  register-file write port.
REQ-009 stall, kill  output  1 each  hold fetch / squash the fetched instruction.
REQ-010 PCSrc  output  2  00 sequential, 01 branch, 10 jump/call, 11 return.
REQ-011 Branch_TA, Jump_TA, For_TA  output  16 each  redirect targets.
REQ-012 idex_opcode 4, idex_func 3, idex_rd 3, idex_a 16, idex_b 16, idex_imm 16, idex_pc1 16, idex_reg_write 1, idex_mem_read 1, idex_mem_write 1  outputs  registered ID/EX fields.
REQ-013 num_branches_taken  output  16  count of taken redirects.

Function
REQ-014 Encoding SHALL be: [15:12] opcode, [11:9] rd, [8:6] rs, [5:3] rt, [2:0] func, [5:0] imm6, [11:0] off12.
REQ-015 Opcodes SHALL be: 0 R-type, 1 ADDI, 2 LW, 3 SW, 4 BEQ(rd,rs), 5 BNE(rd,rs), 6 JMP, 7 CALL, 8 RET; 9-F decode as NOP; 16'h0000 is NOP.
REQ-016 IF/ID register SHALL load if_instruction/if_new_pc on each edge when stall=0 and hold when stall=1.
REQ-017 Register file SHALL be 8x16; R0 reads 0 and ignores writes; write on clk edge when wb_we=1; same-cycle read of wb_rd SHALL return wb_data.
REQ-018 Operand priority SHALL be: R0 -> 0, then MEM forward (mem_reg_write, mem_rd match), then WB bypass, then register file.
REQ-019 Load-use stall: stall=1 when ex_mem_read=1, ex_rd!=0 and ex_rd equals any source register read by the ID instruction.
REQ-020 Branch/RET stall: stall=1 when ex_reg_write=1, ex_rd!=0 and ex_rd is a BEQ/BNE/RET source (R7 for RET).
REQ-021 On stall, ID/EX SHALL load a bubble (all control bits 0, opcode 0) and PCSrc SHALL be 00.
REQ-022 Without stall: BEQ equal / BNE unequal -> PCSrc=01; JMP, CALL -> 10; RET -> 11; else 00.
REQ-023 Branch_TA = ifid_pc1 + sext(imm6); Jump_TA = ifid_pc1 + sext(off12); For_TA = R7 operand; all modulo 2^16.
REQ-024 kill SHALL equal (PCSrc != 00), combinational, same cycle.
REQ-025 CALL SHALL pass rd=7, idex_a=ifid_pc1, reg_write=1 to EX.
REQ-026 idex_reg_write=1 for R-type, ADDI, LW, CALL only when destination != R0; mem_read for LW; mem_write for SW.
REQ-027 idex_imm SHALL be sext(imm6) for ADDI/LW/SW, else 0.
REQ-028 num_branches_taken SHALL increment on each edge with PCSrc != 00, saturating at 16'hFFFF.
REQ-029 stall and kill SHALL never be simultaneously 1.

Reset
REQ-030 rst_n=0 SHALL immediately clear IF/ID, ID/EX, registers R1-R7 and num_branches_taken to 0; stall, kill, PCSrc read 0.
REQ-031 Reset mid-stall SHALL abandon the stall; first post-reset edge loads if_instruction normally.

Verification
REQ-032 LW R1,0(R2) in EX (ex_mem_read=1, ex_rd=1), ID holds ADD R3,R1,R4 -> stall=1 one cycle, bubble in ID/EX, ADD issues next cycle.
REQ-033 R1=R2=5, BEQ R1,R2,+3 at ifid_pc1=16'h0010 -> PCSrc=01, Branch_TA=16'h0013, kill=1, counter +1.
REQ-034 CALL off12=-2 at ifid_pc1=16'h0001 -> Jump_TA=16'hFFFF, idex_rd=7, idex_a=16'h0001.
REQ-035 mem_rd=3, mem_value=16'hABCD and wb_rd=3, wb_data=16'h1111 same cycle, ID reads R3 -> idex_a=16'hABCD.
REQ-036 Write R0=16'h00FF via WB, then read R0 -> 0; counter at 16'hFFFF plus taken branch -> stays 16'hFFFF.
REQ-037 Assert rst_n=0 during a load-use stall -> all outputs 0 immediately; after release, NOP stream gives PCSrc=00.
